// File: rtl/ast_mxu_feed_buffer_sv_if.sv
// Load/feed bus between the DMA read path, the feed buffer and the MXU.
// The feed buffer is the slave side; the DMA/controller drives the master side.
interface ast_mxu_feed_buffer_sv_if #(
  parameter int SIZE      = 6,
  parameter int DATAWIDTH = 14
);
  localparam int DIMW = $clog2(SIZE) + 1;

  logic [DIMW-1:0]           depth;
  logic [DIMW-1:0]           width;
  logic                      set;
  logic                      wen;
  logic [DATAWIDTH-1:0]      data_in;
  logic                      start;
  logic                      busy;
  logic                      loaded_a;
  logic                      loaded_b;
  logic                      feed_valid;
  logic [SIZE*DATAWIDTH-1:0] feed_a;
  logic [SIZE*DATAWIDTH-1:0] feed_b;
  logic                      err;

  modport master (
    output depth, width, set, wen, data_in, start,
    input  busy, loaded_a, loaded_b, feed_valid,
    input  feed_a, feed_b, err
  );

  modport slave (
    input  depth, width, set, wen, data_in, start,
    output busy, loaded_a, loaded_b, feed_valid,
    output feed_a, feed_b, err
  );
endinterface

// File: rtl/ast_mxu_feed_buffer_sv.sv
// Operand feed buffer: captures row-major A/B matrices from the DMA
// and replays them as diagonally skewed lane vectors into the MXU.
module ast_mxu_feed_buffer_sv #(
  parameter int SIZE      = 6,
  parameter int DATAWIDTH = 14
) (
  input logic                     clk,
  input logic                     reset,
  ast_mxu_feed_buffer_sv_if.slave bus
);
  localparam int DIMW = $clog2(SIZE) + 1;
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int TW   = DIMW + 1;
  localparam int VW   = SIZE * DATAWIDTH;

  localparam logic [DIMW-1:0] SZ   = DIMW'(SIZE);
  localparam logic [TW-1:0]   TAIL = TW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FEED
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   col_q, col_d;
  logic [DIMW-1:0] ld_d_q, ld_d_d;
  logic [DIMW-1:0] ld_w_q, ld_w_d;
  logic            ld_bank_q, ld_bank_d;

  logic [DIMW-1:0] da_q, da_d;
  logic [DIMW-1:0] wa_q, wa_d;
  logic [DIMW-1:0] db_q, db_d;
  logic [DIMW-1:0] wb_q, wb_d;
  logic [DIMW-1:0] k_q, k_d;
  logic [TW-1:0]   t_q, t_d;

  logic            busy_q, busy_d;
  logic            loaded_a_q, loaded_a_d;
  logic            loaded_b_q, loaded_b_d;
  logic            feed_valid_q, feed_valid_d;
  logic            err_q, err_d;
  logic [VW-1:0]   feed_a_q, feed_a_d;
  logic [VW-1:0]   feed_b_q, feed_b_d;

  logic [DATAWIDTH-1:0] bank_a_q [SIZE][SIZE];
  logic [DATAWIDTH-1:0] bank_a_d [SIZE][SIZE];
  logic [DATAWIDTH-1:0] bank_b_q [SIZE][SIZE];
  logic [DATAWIDTH-1:0] bank_b_d [SIZE][SIZE];

  logic            dims_ok;
  logic            first_wr;
  logic            cont_wr;
  logic            do_write;
  logic            start_ok;
  logic            emit;
  logic [TW-1:0]   feed_t;
  logic [AW-1:0]   wr_row;
  logic [AW-1:0]   wr_col;
  logic            wr_bank;
  logic [DIMW-1:0] cur_d;
  logic [DIMW-1:0] cur_w;
  int              off;

  assign dims_ok = (bus.depth != '0) && (bus.width != '0) &&
                   (bus.depth <= SZ) && (bus.width <= SZ);

  // Next-state: load sequencing, start acceptance and skewed lane generation
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    ld_d_d       = ld_d_q;
    ld_w_d       = ld_w_q;
    ld_bank_d    = ld_bank_q;
    da_d         = da_q;
    wa_d         = wa_q;
    db_d         = db_q;
    wb_d         = wb_q;
    k_d          = k_q;
    t_d          = t_q;
    busy_d       = busy_q;
    loaded_a_d   = loaded_a_q;
    loaded_b_d   = loaded_b_q;
    err_d        = err_q;
    bank_a_d     = bank_a_q;
    bank_b_d     = bank_b_q;
    feed_valid_d = 1'b0;
    feed_a_d     = '0;
    feed_b_d     = '0;
    first_wr     = 1'b0;
    cont_wr      = 1'b0;
    do_write     = 1'b0;
    start_ok     = 1'b0;
    emit         = 1'b0;
    feed_t       = '0;
    wr_row       = '0;
    wr_col       = '0;
    wr_bank      = 1'b0;
    cur_d        = '0;
    cur_w        = '0;
    off          = 0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (loaded_a_q && loaded_b_q && (wa_q == db_q)) begin
            start_ok = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.wen && !start_ok) begin
          first_wr = 1'b1;
        end
      end
      LOAD: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        // A bank switch abandons the partial matrix
        if (bus.set != ld_bank_q) begin
          if (bus.wen) begin
            first_wr = 1'b1;
          end else begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
          end
        end else if (bus.wen) begin
          cont_wr = 1'b1;
        end
      end
      FEED: begin
        if (bus.wen) begin
          err_d = 1'b1;
        end
        if (t_q == TW'(k_q) + TAIL) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          loaded_a_d = 1'b0;
          loaded_b_d = 1'b0;
          t_d        = '0;
        end else begin
          emit   = 1'b1;
          feed_t = t_q;
          t_d    = t_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // First vector leaves on the accepting edge, so t starts at 1 here
    if (start_ok) begin
      state_d = FEED;
      k_d     = wa_q;
      busy_d  = 1'b1;
      emit    = 1'b1;
      feed_t  = '0;
      t_d     = TW'(1);
    end

    if (first_wr) begin
      row_d = '0;
      col_d = '0;
      if (dims_ok) begin
        ld_d_d    = bus.depth;
        ld_w_d    = bus.width;
        ld_bank_d = bus.set;
        if (bus.set) begin
          loaded_b_d = 1'b0;
          db_d       = bus.depth;
          wb_d       = bus.width;
        end else begin
          loaded_a_d = 1'b0;
          da_d       = bus.depth;
          wa_d       = bus.width;
        end
        do_write = 1'b1;
        wr_bank  = bus.set;
        cur_d    = bus.depth;
        cur_w    = bus.width;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end

    if (cont_wr) begin
      do_write = 1'b1;
      wr_row   = row_q;
      wr_col   = col_q;
      wr_bank  = ld_bank_q;
      cur_d    = ld_d_q;
      cur_w    = ld_w_q;
    end

    if (do_write) begin
      if (wr_bank) begin
        bank_b_d[wr_row][wr_col] = bus.data_in;
      end else begin
        bank_a_d[wr_row][wr_col] = bus.data_in;
      end
      if (DIMW'(wr_col) == cur_w - 1'b1) begin
        col_d = '0;
        if (DIMW'(wr_row) == cur_d - 1'b1) begin
          row_d   = '0;
          state_d = IDLE;
          if (wr_bank) begin
            loaded_b_d = 1'b1;
          end else begin
            loaded_a_d = 1'b1;
          end
        end else begin
          row_d   = wr_row + 1'b1;
          state_d = LOAD;
        end
      end else begin
        row_d   = wr_row;
        col_d   = wr_col + 1'b1;
        state_d = LOAD;
      end
    end

    // Lane i carries element t-i; lanes outside the latched dims read 0
    for (int i = 0; i < SIZE; i++) begin
      off = int'(feed_t) - i;
      if (emit && (off >= 0) && (off < int'(k_d))) begin
        if (i < int'(da_q)) begin
          feed_a_d[i*DATAWIDTH +: DATAWIDTH] =
            bank_a_q[AW'(i)][off[AW-1:0]];
        end
        if (i < int'(wb_q)) begin
          feed_b_d[i*DATAWIDTH +: DATAWIDTH] =
            bank_b_q[off[AW-1:0]][AW'(i)];
        end
      end
    end
    feed_valid_d = emit;
  end

  // State, banks and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      ld_d_q       <= '0;
      ld_w_q       <= '0;
      ld_bank_q    <= 1'b0;
      da_q         <= '0;
      wa_q         <= '0;
      db_q         <= '0;
      wb_q         <= '0;
      k_q          <= '0;
      t_q          <= '0;
      busy_q       <= 1'b0;
      loaded_a_q   <= 1'b0;
      loaded_b_q   <= 1'b0;
      feed_valid_q <= 1'b0;
      err_q        <= 1'b0;
      feed_a_q     <= '0;
      feed_b_q     <= '0;
      bank_a_q     <= '{default: '0};
      bank_b_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ld_d_q       <= ld_d_d;
      ld_w_q       <= ld_w_d;
      ld_bank_q    <= ld_bank_d;
      da_q         <= da_d;
      wa_q         <= wa_d;
      db_q         <= db_d;
      wb_q         <= wb_d;
      k_q          <= k_d;
      t_q          <= t_d;
      busy_q       <= busy_d;
      loaded_a_q   <= loaded_a_d;
      loaded_b_q   <= loaded_b_d;
      feed_valid_q <= feed_valid_d;
      err_q        <= err_d;
      feed_a_q     <= feed_a_d;
      feed_b_q     <= feed_b_d;
      bank_a_q     <= bank_a_d;
      bank_b_q     <= bank_b_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.loaded_a   = loaded_a_q;
  assign bus.loaded_b   = loaded_b_q;
  assign bus.feed_valid = feed_valid_q;
  assign bus.feed_a     = feed_a_q;
  assign bus.feed_b     = feed_b_q;
  assign bus.err        = err_q;
endmodule
